// File: rtl/platform_pkg.sv
// Shared constants and types for the platform scanline renderer.
package platform_pkg;

  localparam int          SPR_W     = 16;
  localparam int          SPR_H     = 8;
  localparam int          SCREEN_W  = 640;
  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } plat_rend_state_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } plat_slot_t;

  // The >= test guards the subtraction, so the 10-bit difference never wraps.
  function automatic logic slot_hit(input plat_slot_t s, input logic [9:0] y);
    return s.valid && (y >= s.y) && ((y - s.y) < 10'(SPR_H));
  endfunction

endpackage

// File: rtl/plat_line_renderer.sv
// Per-scanline platform sprite renderer: scans every slot, fetches the
// overlapping sprite row and writes opaque, on-screen pixels to the line buffer.
//
//   state | meaning
//   IDLE  | waiting for line_start
//   CHECK | one cycle per slot, overlap test against the latched line
//   FETCH | SPR_W cycles issuing sprite row reads for the hit slot
//   DONE  | one-cycle done pulse, then back to IDLE
module plat_line_renderer
  import platform_pkg::*;
#(
  parameter int NUM_PLATS = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      line_start,
  input  logic [9:0]                line_y,
  input  logic [NUM_PLATS-1:0]      plat_valid,
  input  logic [NUM_PLATS-1:0][9:0] plat_x,
  input  logic [NUM_PLATS-1:0][9:0] plat_y,
  output logic [7:0]                rom_addr,
  input  logic [23:0]               rom_data,
  output logic                      lb_we,
  output logic [9:0]                lb_addr,
  output logic [23:0]               lb_data,
  output logic                      busy,
  output logic                      done
);

  localparam int SLOT_W = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
  localparam int COL_W  = $clog2(SPR_W);

  plat_rend_state_t  state_q, state_d;
  logic [9:0]        cur_y_q, cur_y_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [2:0]        row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              issued_q, issued_d;
  logic [10:0]       xpos_q, xpos_d;

  plat_slot_t cur_slot;
  logic       hit;
  logic       last_slot;
  logic       col_last;

  // Current slot record and its overlap/terminal decodes.
  always_comb begin
    cur_slot.valid = plat_valid[slot_q];
    cur_slot.x     = plat_x[slot_q];
    cur_slot.y     = plat_y[slot_q];
    hit            = slot_hit(cur_slot, cur_y_q);
    last_slot      = (slot_q == SLOT_W'(NUM_PLATS - 1));
    col_last       = (col_q == COL_W'(SPR_W - 1));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cur_y_q  <= '0;
      slot_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      issued_q <= 1'b0;
      xpos_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_y_q  <= cur_y_d;
      slot_q   <= slot_d;
      row_q    <= row_d;
      col_q    <= col_d;
      issued_q <= issued_d;
      xpos_q   <= xpos_d;
    end
  end

  // Next-state logic; line_start outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (line_start) state_d = CHECK;
      CHECK: begin
        if (hit)            state_d = FETCH;
        else if (last_slot) state_d = DONE;
      end
      FETCH: if (col_last) state_d = last_slot ? DONE : CHECK;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: line latch, slot/column walk and the read-issue pipe.
  always_comb begin
    cur_y_d  = cur_y_q;
    slot_d   = slot_q;
    row_d    = row_q;
    col_d    = col_q;
    issued_d = 1'b0;
    xpos_d   = xpos_q;
    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          cur_y_d = line_y;
          slot_d  = '0;
        end
      end
      CHECK: begin
        if (hit) begin
          row_d = 3'(cur_y_q - cur_slot.y);
          col_d = '0;
        end else if (!last_slot) begin
          slot_d = slot_q + 1'b1;
        end
      end
      FETCH: begin
        issued_d = 1'b1;
        xpos_d   = {1'b0, cur_slot.x} + 11'(col_q);
        col_d    = col_q + 1'b1;
        if (col_last && !last_slot) slot_d = slot_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs: read address while fetching, writes from the delayed issue stage.
  always_comb begin
    rom_addr = (state_q == FETCH) ? {1'b0, row_q, col_q} : 8'd0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    lb_we    = issued_q && (rom_data != KEY_COLOR) && (xpos_q < 11'(SCREEN_W));
    lb_addr  = issued_q ? xpos_q[9:0] : 10'd0;
    lb_data  = issued_q ? rom_data : 24'd0;
  end

endmodule

// File: tb/tb_plat_line_renderer.sv
// Self-checking bench for plat_line_renderer against a per-cycle schedule model.
module tb_plat_line_renderer;
  import platform_pkg::*;

  localparam int N = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              line_start;
  logic [9:0]        line_y;
  logic [N-1:0]      plat_valid;
  logic [N-1:0][9:0] plat_x;
  logic [N-1:0][9:0] plat_y;
  logic [7:0]        rom_addr;
  logic [23:0]       rom_data;
  logic              lb_we;
  logic [9:0]        lb_addr;
  logic [23:0]       lb_data;
  logic              busy;
  logic              done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [23:0] rom [128];
  logic [23:0] obs_lb [1024];
  int          exp_addr [200];
  bit          exp_we [200];
  int          exp_la [200];
  logic [23:0] exp_ld [200];
  int          exp_t;
  int          last_wr;
  int          last_done_at;

  always #5 Clk = ~Clk;

  plat_line_renderer #(.NUM_PLATS(N)) dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
    .plat_valid(plat_valid), .plat_x(plat_x), .plat_y(plat_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_data(lb_data), .busy(busy), .done(done)
  );

  // Sprite memory with one cycle of read latency.
  always @(posedge Clk) rom_data <= rom[rom_addr[6:0]];

  task automatic clear_slots();
    plat_valid = '0;
    plat_x     = '0;
    plat_y     = '0;
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < 128; i++) begin
      rom[i] = 24'($urandom);
      if ($urandom_range(0, 7) == 0) rom[i] = KEY_COLOR;
    end
  endtask

  // Expected per-cycle schedule: cycle 1 is the first cycle after line_start.
  task automatic build_model(input int ly);
    int t;
    for (int i = 0; i < 200; i++) begin
      exp_addr[i] = 0; exp_we[i] = 0; exp_la[i] = 0; exp_ld[i] = '0;
    end
    t = 1;
    for (int s = 0; s < N; s++) begin
      int px, py, row;
      bit h;
      px = int'(plat_x[s]);
      py = int'(plat_y[s]);
      h  = plat_valid[s] && (ly >= py) && (ly - py < SPR_H);
      t++;
      if (h) begin
        row = ly - py;
        for (int c = 0; c < SPR_W; c++) begin
          logic [23:0] pix;
          int x;
          pix = rom[row * SPR_W + c];
          x   = px + c;
          exp_addr[t] = row * SPR_W + c;
          if (pix != KEY_COLOR && x < SCREEN_W) begin
            exp_we[t+1] = 1; exp_la[t+1] = x; exp_ld[t+1] = pix;
          end
          t++;
        end
      end
    end
    exp_t = t;
  endtask

  // Run one line, comparing every cycle; extra>0 pulses line_start again at that cycle.
  task automatic run_line(input string name, input int ly, input int extra);
    int done_cnt, wr;
    bit ok;
    done_cnt = 0; wr = 0; last_done_at = -1;
    for (int i = 0; i < 1024; i++) obs_lb[i] = '0;
    build_model(ly);
    @(negedge Clk);
    line_start = 1'b1;
    line_y     = 10'(ly);
    @(negedge Clk);
    line_start = 1'b0;
    for (int t = 1; t <= exp_t + 1; t++) begin
      ok = (busy === (t <= exp_t)) && (done === (t == exp_t)) &&
           (rom_addr === 8'(exp_addr[t])) && (lb_we === exp_we[t]) &&
           (!exp_we[t] || (lb_addr === 10'(exp_la[t]) && lb_data === exp_ld[t]));
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s cycle %0d: got busy=%b done=%b rom_addr=%h lb_we=%b lb_addr=%0d lb_data=%h; want busy=%b done=%b rom_addr=%h lb_we=%b lb_addr=%0d lb_data=%h",
                    name, t, busy, done, rom_addr, lb_we, lb_addr, lb_data,
                    t <= exp_t, t == exp_t, 8'(exp_addr[t]), exp_we[t], exp_la[t], exp_ld[t]);
      if (done === 1'b1) begin done_cnt++; last_done_at = t; end
      if (lb_we === 1'b1) begin wr++; obs_lb[lb_addr] = lb_data; end
      if (t == extra) begin
        line_start = 1'b1;
        line_y     = 10'($urandom_range(0, 479));
      end else begin
        line_start = 1'b0;
      end
      @(negedge Clk);
    end
    line_start = 1'b0;
    last_wr = wr;
    total_cnt++;
    if (done_cnt == 1) pass_cnt++;
    else $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
  endtask

  task automatic check_idle_outputs(input string name);
    total_cnt++;
    if (rom_addr === 8'd0 && lb_we === 1'b0 && lb_addr === 10'd0 && lb_data === 24'd0 &&
        busy === 1'b0 && done === 1'b0) pass_cnt++;
    else $display("FAIL %s: got rom_addr=%h lb_we=%b lb_addr=%0d lb_data=%h busy=%b done=%b; want all zero",
                  name, rom_addr, lb_we, lb_addr, lb_data, busy, done);
  endtask

  task automatic test_reset();
    Reset = 1'b1; line_start = 1'b0; line_y = '0;
    clear_slots();
    fill_rom_random();
    @(negedge Clk);
    @(negedge Clk);
    check_idle_outputs("reset_state");
    Reset = 1'b0;
    @(negedge Clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_single();
    clear_slots();
    fill_rom_random();
    plat_valid[0] = 1'b1; plat_x[0] = 10'd100; plat_y[0] = 10'd50;
    run_line("single_slot", 53, 0);
    total_cnt++;
    if (last_done_at == N + SPR_W + 1) pass_cnt++;
    else $display("FAIL single_done_cycle: got %0d want %0d", last_done_at, N + SPR_W + 1);
  endtask

  task automatic test_all_invalid();
    clear_slots();
    run_line("all_invalid", 200, 0);
    total_cnt++;
    if (last_wr == 0 && last_done_at == N + 1) pass_cnt++;
    else $display("FAIL all_invalid: got writes=%0d done_at=%0d want 0 and %0d", last_wr, last_done_at, N + 1);
  endtask

  task automatic test_key_color();
    clear_slots();
    for (int c = 0; c < SPR_W; c++) rom[c] = 24'(c * 24'h010203 + 24'h000100);
    rom[3] = KEY_COLOR; rom[7] = KEY_COLOR;
    plat_valid[2] = 1'b1; plat_x[2] = 10'd0; plat_y[2] = 10'd300;
    run_line("key_color", 300, 0);
    total_cnt++;
    if (last_wr == 14) pass_cnt++;
    else $display("FAIL key_color_writes: got %0d want 14", last_wr);
  endtask

  task automatic test_clip();
    clear_slots();
    for (int c = 0; c < SPR_W; c++) rom[c] = 24'h00AA00 + 24'(c);
    plat_valid[5] = 1'b1; plat_x[5] = 10'd630; plat_y[5] = 10'd10;
    run_line("clip", 10, 0);
    total_cnt++;
    if (last_wr == 10) pass_cnt++;
    else $display("FAIL clip_writes: got %0d want 10", last_wr);
  endtask

  task automatic test_overlap();
    clear_slots();
    for (int c = 0; c < SPR_W; c++) rom[3 * SPR_W + c] = 24'h123400 + 24'(c);
    plat_valid[1] = 1'b1; plat_x[1] = 10'd100; plat_y[1] = 10'd200;
    plat_valid[4] = 1'b1; plat_x[4] = 10'd108; plat_y[4] = 10'd200;
    run_line("overlap", 203, 0);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (obs_lb[108 + i] === rom[3 * SPR_W + i]) pass_cnt++;
      else $display("FAIL overlap_px%0d: got %h want %h", 108 + i, obs_lb[108 + i], rom[3 * SPR_W + i]);
    end
    run_line("below_sprite", 208, 0);
    total_cnt++;
    if (last_wr == 0) pass_cnt++;
    else $display("FAIL below_sprite_writes: got %0d want 0", last_wr);
    clear_slots();
    plat_valid[0] = 1'b1; plat_x[0] = 10'd40; plat_y[0] = 10'd1020;
    run_line("no_wrap", 5, 0);
    total_cnt++;
    if (last_wr == 0) pass_cnt++;
    else $display("FAIL no_wrap_writes: got %0d want 0", last_wr);
  endtask

  task automatic test_worst_case();
    clear_slots();
    fill_rom_random();
    for (int s = 0; s < N; s++) begin
      plat_valid[s] = 1'b1;
      plat_x[s] = 10'($urandom_range(0, 639));
      plat_y[s] = 10'd77;
    end
    run_line("worst_case", 80, 0);
    total_cnt++;
    if (last_done_at == 137) pass_cnt++;
    else $display("FAIL worst_done_cycle: got %0d want 137", last_done_at);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int ly;
      fill_rom_random();
      clear_slots();
      ly = $urandom_range(0, 479);
      for (int s = 0; s < N; s++) begin
        int py;
        plat_valid[s] = 1'($urandom_range(0, 1));
        plat_x[s] = 10'($urandom_range(0, 660));
        py = ly - int'($urandom_range(0, 10));
        plat_y[s] = (py < 0) ? 10'($urandom_range(0, 1023)) : 10'(py);
      end
      run_line("random", ly, 0);
    end
  endtask

  task automatic test_back_to_back();
    clear_slots();
    fill_rom_random();
    plat_valid[3] = 1'b1; plat_x[3] = 10'd320; plat_y[3] = 10'd60;
    plat_valid[6] = 1'b1; plat_x[6] = 10'd325; plat_y[6] = 10'd58;
    run_line("ignored_start", 62, 6);
    run_line("back_to_back", 59, 0);
  endtask

  task automatic test_reset_mid();
    clear_slots();
    fill_rom_random();
    plat_valid[0] = 1'b1; plat_x[0] = 10'd100; plat_y[0] = 10'd50;
    @(negedge Clk);
    line_start = 1'b1; line_y = 10'd53;
    @(negedge Clk);
    line_start = 1'b0;
    repeat (7) @(negedge Clk);
    total_cnt++;
    if (rom_addr === 8'h36 && busy === 1'b1) pass_cnt++;
    else $display("FAIL mid_fetch_col6: got rom_addr=%h busy=%b want 36 and 1", rom_addr, busy);
    Reset = 1'b1;
    @(negedge Clk);
    check_idle_outputs("reset_mid_fetch");
    Reset = 1'b0;
    @(negedge Clk);
    check_idle_outputs("idle_after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_invalid();
    test_key_color();
    test_clip();
    test_overlap();
    test_worst_case();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
